// File: rtl/pc_sequencer.sv
// Program-counter and execution-state sequencer for the single-cycle core.
// Resolves branches and jumps, and handles WAIT/HALT plus user-context entry, quantum preemption and traps.
module pc_sequencer #(
  parameter int ADDR_W   = 10,
  parameter int QUANTUM  = 64,
  parameter int OS_ENTRY = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              PCSrc,
  input  logic [2:0]        Tipo_Branch,
  input  logic              zero,
  input  logic              neg,
  input  logic [31:0]       imm,
  input  logic [31:0]       reg_target,
  input  logic              HALT,
  input  logic              WAIT,
  input  logic              Set_ctx,
  input  logic              resume,
  output logic [ADDR_W-1:0] pc,
  output logic [ADDR_W-1:0] pc_plus1,
  output logic              cpu_en,
  output logic              ctx_active,
  output logic [ADDR_W-1:0] saved_pc,
  output logic [1:0]        trap_cause,
  output logic              halted,
  output logic              waiting
);

  localparam int CNT_W = (QUANTUM > 2) ? $clog2(QUANTUM) : 1;
  localparam logic [1:0] CAUSE_NONE    = 2'd0;
  localparam logic [1:0] CAUSE_HALT    = 2'd1;
  localparam logic [1:0] CAUSE_QUANTUM = 2'd2;

  typedef enum logic [1:0] {RUN, WAITING, HALTED} state_t;

  state_t              state, state_nx;
  logic [ADDR_W-1:0]   pc_nx, saved_pc_nx, target, next_seq;
  logic                ctx_nx, taken, expire;
  logic [1:0]          cause_nx;
  logic [CNT_W-1:0]    cnt, cnt_nx;

  // Only the low address bits of the offset and jump register are meaningful.
  logic unused_hi;
  assign unused_hi = ^{imm[31:ADDR_W], reg_target[31:ADDR_W]};

  assign pc_plus1 = pc + ADDR_W'(1);
  assign cpu_en   = (state == RUN) && rst_n;
  assign halted   = (state == HALTED);
  assign waiting  = (state == WAITING);

  always_comb begin
    taken = 1'b0;
    case (Tipo_Branch)
      3'd1:    taken = zero;
      3'd2:    taken = !zero;
      3'd3:    taken = neg;
      3'd4:    taken = !neg;
      3'd6:    taken = 1'b1;
      3'd7:    taken = 1'b1;
      default: taken = 1'b0;
    endcase
    taken    = taken && PCSrc;
    target   = (Tipo_Branch == 3'd7) ? reg_target[ADDR_W-1:0] : pc + imm[ADDR_W-1:0];
    next_seq = taken ? target : pc_plus1;
    expire   = ctx_active && (cnt == CNT_W'(QUANTUM - 1));
  end

  always_comb begin
    state_nx    = state;
    pc_nx       = pc;
    ctx_nx      = ctx_active;
    saved_pc_nx = saved_pc;
    cause_nx    = trap_cause;
    cnt_nx      = cnt;
    case (state)
      RUN: begin
        if (HALT && !ctx_active) begin
          state_nx = HALTED;
        end else if (HALT) begin
          saved_pc_nx = pc;
          pc_nx       = ADDR_W'(OS_ENTRY);
          ctx_nx      = 1'b0;
          cause_nx    = CAUSE_HALT;
          cnt_nx      = '0;
        end else if (WAIT) begin
          state_nx = WAITING;
        end else if (Set_ctx) begin
          pc_nx    = reg_target[ADDR_W-1:0];
          ctx_nx   = 1'b1;
          cnt_nx   = '0;
          cause_nx = CAUSE_NONE;
        end else if (expire) begin
          // The expiring instruction commits; its successor becomes the resume point.
          saved_pc_nx = next_seq;
          pc_nx       = ADDR_W'(OS_ENTRY);
          ctx_nx      = 1'b0;
          cause_nx    = CAUSE_QUANTUM;
          cnt_nx      = '0;
        end else begin
          pc_nx = next_seq;
          if (ctx_active) cnt_nx = cnt + CNT_W'(1);
        end
      end
      WAITING: begin
        if (resume) begin
          pc_nx    = pc_plus1;
          state_nx = RUN;
        end
      end
      HALTED: ;
      default: state_nx = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= RUN;
      pc         <= '0;
      ctx_active <= 1'b0;
      saved_pc   <= '0;
      trap_cause <= CAUSE_NONE;
      cnt        <= '0;
    end else begin
      state      <= state_nx;
      pc         <= pc_nx;
      ctx_active <= ctx_nx;
      saved_pc   <= saved_pc_nx;
      trap_cause <= cause_nx;
      cnt        <= cnt_nx;
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: expected post-edge state is queued with each stimulus
// and popped for comparison once the edge has been taken.
module tb_pc_sequencer;
  localparam int AW = 10;

  logic          clk = 1'b0;
  logic          rst_n, PCSrc, zero, neg, HALT, WAIT, Set_ctx, resume;
  logic [2:0]    Tipo_Branch;
  logic [31:0]   imm, reg_target;
  logic [AW-1:0] pc, pc_plus1, saved_pc;
  logic          cpu_en, ctx_active, halted, waiting;
  logic [1:0]    trap_cause;

  pc_sequencer #(.ADDR_W(AW), .QUANTUM(64), .OS_ENTRY(16)) dut (
    .clk(clk), .rst_n(rst_n), .PCSrc(PCSrc), .Tipo_Branch(Tipo_Branch),
    .zero(zero), .neg(neg), .imm(imm), .reg_target(reg_target),
    .HALT(HALT), .WAIT(WAIT), .Set_ctx(Set_ctx), .resume(resume),
    .pc(pc), .pc_plus1(pc_plus1), .cpu_en(cpu_en), .ctx_active(ctx_active),
    .saved_pc(saved_pc), .trap_cause(trap_cause), .halted(halted), .waiting(waiting)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [AW-1:0] pc;
    logic          en, ctx;
    logic [AW-1:0] sp;
    logic [1:0]    cause;
    logic          h, w;
  } exp_t;

  exp_t sb[$];
  int   n_chk = 0, n_pass = 0;

  // Expected architectural state after the next edge (0 RUN, 1 WAITING, 2 HALTED).
  int         e_pc, e_sp, e_st;
  logic       e_ctx;
  logic [1:0] e_cause;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic idle();
    PCSrc = 0; Tipo_Branch = 0; zero = 0; neg = 0; imm = 0; reg_target = 0;
    HALT = 0; WAIT = 0; Set_ctx = 0; resume = 0;
  endtask

  task automatic tick(input string tag);
    exp_t          e;
    logic [AW-1:0] p1;
    e.pc = AW'(e_pc); e.en = (e_st == 0) && rst_n; e.ctx = e_ctx;
    e.sp = AW'(e_sp); e.cause = e_cause; e.h = (e_st == 2); e.w = (e_st == 1);
    sb.push_back(e);
    @(posedge clk); #1;
    e  = sb.pop_front();
    p1 = e.pc + AW'(1);
    check({tag, ".pc"},       32'(pc),         32'(e.pc));
    check({tag, ".pc_plus1"}, 32'(pc_plus1),   32'(p1));
    check({tag, ".cpu_en"},   32'(cpu_en),     32'(e.en));
    check({tag, ".ctx"},      32'(ctx_active), 32'(e.ctx));
    check({tag, ".saved_pc"}, 32'(saved_pc),   32'(e.sp));
    check({tag, ".cause"},    32'(trap_cause), 32'(e.cause));
    check({tag, ".halted"},   32'(halted),     32'(e.h));
    check({tag, ".waiting"},  32'(waiting),    32'(e.w));
    idle();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      e_pc = (e_pc + 1) % 1024;
      tick("seq");
    end
  endtask

  task automatic exp_reset();
    e_pc = 0; e_sp = 0; e_st = 0; e_ctx = 0; e_cause = 0;
  endtask

  initial begin
    rst_n = 0; idle(); exp_reset();
    tick("reset");
    rst_n = 1; #1;
    check("en_after_rst", 32'(cpu_en), 32'd1);

    run(5);
    PCSrc = 1; Tipo_Branch = 1; zero = 1; imm = -3;  e_pc = 2;    tick("beq_t");
    run(3);
    PCSrc = 1; Tipo_Branch = 2; zero = 1; imm = -3;  e_pc = 6;    tick("bne_nt");
    PCSrc = 1; Tipo_Branch = 7; reg_target = 32'h3ff; e_pc = 1023; tick("jr");
    run(1);
    run(5);
    PCSrc = 1; Tipo_Branch = 5; imm = 7;             e_pc = 6;    tick("tb5");
    PCSrc = 1; Tipo_Branch = 3; neg = 1; imm = 4;    e_pc = 10;   tick("blt_t");
    PCSrc = 1; Tipo_Branch = 4; neg = 1; imm = 4;    e_pc = 11;   tick("bge_nt");
    PCSrc = 1; Tipo_Branch = 6; imm = -4;            e_pc = 7;    tick("jal");
    PCSrc = 0; Tipo_Branch = 6; imm = 5;             e_pc = 8;    tick("nopcsrc");

    WAIT = 1; e_st = 1; tick("wait");
    PCSrc = 1; Tipo_Branch = 6; imm = 5; Set_ctx = 1; tick("wait_hold1");
    tick("wait_hold2");
    tick("wait_hold3");
    resume = 1; e_pc = 9; e_st = 0; tick("resume");
    resume = 1; e_pc = 10;          tick("resume_run");

    Set_ctx = 1; reg_target = 100; e_pc = 100; e_ctx = 1; e_cause = 0; tick("setctx");
    run(63);
    e_pc = 16; e_sp = 164; e_cause = 2; e_ctx = 0; tick("expire");

    // Counter stays frozen across WAIT; expiry lands on a taken branch.
    Set_ctx = 1; reg_target = 200; e_pc = 200; e_ctx = 1; e_cause = 0; tick("setctx2");
    run(20);
    WAIT = 1; e_st = 1; tick("ctx_wait");
    resume = 1; e_pc = 221; e_st = 0; tick("ctx_resume");
    run(43);
    PCSrc = 1; Tipo_Branch = 1; zero = 1; imm = 10;
    e_pc = 16; e_sp = 274; e_cause = 2; e_ctx = 0; tick("expire_br");

    Set_ctx = 1; reg_target = 120; e_pc = 120; e_ctx = 1; e_cause = 0; tick("setctx3");
    HALT = 1; e_pc = 16; e_sp = 120; e_cause = 1; e_ctx = 0; tick("halt_trap");

    Set_ctx = 1; reg_target = 100; e_pc = 100; e_ctx = 1; e_cause = 0; tick("setctx4");
    run(3);
    rst_n = 0; exp_reset(); tick("rst_ctx");
    rst_n = 1;

    run(1);
    WAIT = 1; e_st = 1; tick("wait2");
    rst_n = 0; exp_reset(); tick("rst_wait");
    rst_n = 1;

    run(2);
    HALT = 1; e_st = 2; tick("halt_os");
    resume = 1; Set_ctx = 1; reg_target = 5; tick("halt_hold1");
    PCSrc = 1; Tipo_Branch = 6; imm = 3; tick("halt_hold2");
    rst_n = 0; exp_reset(); tick("rst_halt");
    rst_n = 1;
    run(1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
